// File: rtl/message_scheduler.sv
// rtl/message_scheduler.sv - SHA-256 message schedule for the second header chunk.
// Emits one registered W[t] per enabled step from a 16-word sliding window.
module message_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clearCounter,
  input  logic        solveEn,
  input  logic [5:0]  cycle,
  input  logic [31:0] nonce,
  input  logic [95:0] headerTail,
  output logic [31:0] wt,
  output logic        wValid,
  output logic [5:0]  wIndex,
  output logic [31:0] nonceOut,
  output logic        blockDone,
  output logic        seqErr
);

  // win[0] is the newest word W[t-1]; win[15] is W[t-16].
  logic [31:0] win [16];
  logic [5:0]  expected;
  logic [31:0] new_word;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  always_comb begin
    new_word = 32'h0;
    if (cycle[5:4] == 2'b00) begin
      // Padding template; W3 takes the latched nonce so the block stays self-consistent.
      case (cycle[3:0])
        4'd0:    new_word = headerTail[95:64];
        4'd1:    new_word = headerTail[63:32];
        4'd2:    new_word = headerTail[31:0];
        4'd3:    new_word = nonceOut;
        4'd4:    new_word = 32'h8000_0000;
        4'd15:   new_word = 32'h0000_0280;
        default: new_word = 32'h0;
      endcase
    end else begin
      new_word = sig1(win[1]) + win[6] + sig0(win[14]) + win[15];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wt        <= 32'h0;
      wValid    <= 1'b0;
      wIndex    <= 6'd0;
      nonceOut  <= 32'h0;
      blockDone <= 1'b0;
      seqErr    <= 1'b0;
      expected  <= 6'd0;
      for (int i = 0; i < 16; i++) win[i] <= 32'h0;
    end else if (clearCounter) begin
      wt        <= 32'h0;
      wValid    <= 1'b0;
      wIndex    <= 6'd0;
      nonceOut  <= 32'h0;
      blockDone <= 1'b0;
      seqErr    <= 1'b0;
      expected  <= 6'd0;
      for (int i = 0; i < 16; i++) win[i] <= 32'h0;
    end else if (solveEn) begin
      wt        <= new_word;
      wValid    <= 1'b1;
      wIndex    <= cycle;
      blockDone <= (cycle == 6'd63);
      expected  <= cycle + 6'd1;
      if (cycle != expected) seqErr <= 1'b1;
      if (cycle == 6'd0) nonceOut <= nonce;
      win[0] <= new_word;
      for (int i = 1; i < 16; i++) win[i] <= win[i-1];
    end else begin
      wValid    <= 1'b0;
      blockDone <= 1'b0;
    end
  end

endmodule

// File: tb/tb_message_scheduler.sv
// tb/tb_message_scheduler.sv - randomized self-checking bench for message_scheduler.
module tb_message_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clearCounter = 1'b0;
  logic        solveEn = 1'b0;
  logic [5:0]  cycle = 6'd0;
  logic [31:0] nonce = 32'h0;
  logic [95:0] headerTail = 96'h0;
  logic [31:0] wt;
  logic        wValid;
  logic [5:0]  wIndex;
  logic [31:0] nonceOut;
  logic        blockDone;
  logic        seqErr;

  int total = 0;
  int bad = 0;
  logic [31:0] gold [64];

  message_scheduler dut (
    .clk(clk), .rst(rst), .clearCounter(clearCounter), .solveEn(solveEn),
    .cycle(cycle), .nonce(nonce), .headerTail(headerTail),
    .wt(wt), .wValid(wValid), .wIndex(wIndex), .nonceOut(nonceOut),
    .blockDone(blockDone), .seqErr(seqErr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Whole-block reference: W[0..63] from the message array directly.
  task automatic compute_gold(input logic [95:0] h, input logic [31:0] n);
    logic [31:0] s0, s1;
    for (int i = 0; i < 64; i++) begin
      if (i < 16) begin
        gold[i] = 32'h0;
        if (i == 0) gold[i] = h[95:64];
        if (i == 1) gold[i] = h[63:32];
        if (i == 2) gold[i] = h[31:0];
        if (i == 3) gold[i] = n;
        if (i == 4) gold[i] = 32'h8000_0000;
        if (i == 15) gold[i] = 32'd640;
      end else begin
        s0 = ror(gold[i-15], 7) ^ ror(gold[i-15], 18) ^ (gold[i-15] >> 3);
        s1 = ror(gold[i-2], 17) ^ ror(gold[i-2], 19) ^ (gold[i-2] >> 10);
        gold[i] = s1 + gold[i-7] + s0 + gold[i-16];
      end
    end
  endtask

  task automatic step(input int t, input logic [31:0] n);
    cycle = 6'(t);
    nonce = n;
    solveEn = 1'b1;
    clearCounter = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    solveEn = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    solveEn = 1'b0;
    clearCounter = 1'b1;
    @(posedge clk);
    #1;
    clearCounter = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({wt, wValid, wIndex, nonceOut, blockDone, seqErr} !== 72'h0) begin
      bad++;
      $display("FAIL reset_state wt=%h v=%b idx=%0d nonce=%h done=%b err=%b required all zero",
               wt, wValid, wIndex, nonceOut, blockDone, seqErr);
    end
    rst = 1'b0;
    #2;
  endtask

  task automatic test_all_zero();
    headerTail = 96'h0;
    compute_gold(96'h0, 32'h0);
    for (int t = 0; t < 64; t++) begin
      step(t, 32'h0);
      total++;
      if (wt !== gold[t] || wValid !== 1'b1 || wIndex !== 6'(t) || blockDone !== (t == 63) || seqErr !== 1'b0) begin
        bad++;
        $display("FAIL all_zero t=%0d wt=%h exp=%h v=%b idx=%0d done=%b err=%b", t, wt, gold[t], wValid, wIndex, blockDone, seqErr);
      end
      if (t == 4 || t == 15 || t == 17 || t == 20) begin
        total++;
        if (wt !== (t == 4 ? 32'h8000_0000 : t == 15 ? 32'h0000_0280 : t == 17 ? 32'h0110_0000 : 32'h8000_0000)) begin
          bad++;
          $display("FAIL all_zero_const t=%0d wt=%h", t, wt);
        end
      end
    end
    idle();
    total++;
    if (wValid !== 1'b0 || blockDone !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse v=%b done=%b required 0 0", wValid, blockDone);
    end
  endtask

  task automatic test_nonce_capture();
    headerTail = {$urandom, $urandom, $urandom};
    compute_gold(headerTail, 32'hDEAD_BEEF);
    for (int t = 0; t < 64; t++) begin
      step(t, t == 0 ? 32'hDEAD_BEEF : 32'h1234_5678);
      total++;
      if (wt !== gold[t] || nonceOut !== 32'hDEAD_BEEF || wValid !== 1'b1) begin
        bad++;
        $display("FAIL nonce_capture t=%0d wt=%h exp=%h nonceOut=%h exp=deadbeef v=%b", t, wt, gold[t], nonceOut, wValid);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] n;
    n = $urandom;
    headerTail = {$urandom, $urandom, $urandom};
    compute_gold(headerTail, n);
    for (int t = 0; t <= 20; t++) step(t, n);
    for (int k = 0; k < 5; k++) begin
      cycle = 6'($urandom_range(0, 63));
      idle();
      total++;
      if (wValid !== 1'b0 || blockDone !== 1'b0 || wt !== gold[20] || wIndex !== 6'd20) begin
        bad++;
        $display("FAIL stall k=%0d v=%b done=%b wt=%h exp=%h idx=%0d", k, wValid, blockDone, wt, gold[20], wIndex);
      end
    end
    for (int t = 21; t < 64; t++) begin
      step(t, $urandom);
      total++;
      if (wt !== gold[t] || wValid !== 1'b1 || seqErr !== 1'b0 || blockDone !== (t == 63)) begin
        bad++;
        $display("FAIL stall_resume t=%0d wt=%h exp=%h v=%b err=%b", t, wt, gold[t], wValid, seqErr);
      end
    end
  endtask

  task automatic test_out_of_seq();
    do_clear();
    for (int t = 0; t < 3; t++) step(t, 32'h5);
    total++;
    if (seqErr !== 1'b0) begin
      bad++;
      $display("FAIL seq_before err=%b required 0", seqErr);
    end
    step(5, 32'h5);
    total++;
    if (seqErr !== 1'b1 || wt !== 32'h0 || wIndex !== 6'd5 || wValid !== 1'b1) begin
      bad++;
      $display("FAIL seq_jump err=%b wt=%h idx=%0d v=%b required 1 0 5 1", seqErr, wt, wIndex, wValid);
    end
    step(6, 32'h5);
    idle();
    total++;
    if (seqErr !== 1'b1) begin
      bad++;
      $display("FAIL seq_sticky err=%b required 1", seqErr);
    end
    cycle = 6'd7;
    solveEn = 1'b1;
    clearCounter = 1'b1;
    @(posedge clk);
    #1;
    clearCounter = 1'b0;
    total++;
    if (seqErr !== 1'b0 || wValid !== 1'b0 || wt !== 32'h0 || wIndex !== 6'd0) begin
      bad++;
      $display("FAIL clear_priority err=%b v=%b wt=%h idx=%0d required all zero", seqErr, wValid, wt, wIndex);
    end
    step(3, 32'h5);
    total++;
    if (seqErr !== 1'b1) begin
      bad++;
      $display("FAIL seq_after_clear err=%b required 1", seqErr);
    end
    do_clear();
  endtask

  task automatic test_async_reset();
    logic [31:0] n;
    n = $urandom;
    headerTail = {$urandom, $urandom, $urandom};
    compute_gold(headerTail, n);
    for (int t = 0; t <= 40; t++) step(t, n);
    solveEn = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if ({wt, wValid, wIndex, nonceOut, blockDone, seqErr} !== 72'h0) begin
      bad++;
      $display("FAIL async_reset wt=%h v=%b idx=%0d nonce=%h done=%b err=%b required all zero",
               wt, wValid, wIndex, nonceOut, blockDone, seqErr);
    end
    #1;
    rst = 1'b0;
    n = $urandom;
    compute_gold(headerTail, n);
    for (int t = 0; t < 64; t++) begin
      step(t, n);
      total++;
      if (wt !== gold[t] || seqErr !== 1'b0 || wValid !== 1'b1) begin
        bad++;
        $display("FAIL after_reset t=%0d wt=%h exp=%h err=%b v=%b", t, wt, gold[t], seqErr, wValid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] n;
    n = $urandom;
    headerTail = {$urandom, $urandom, $urandom};
    compute_gold(headerTail, n);
    for (int t = 0; t < 64; t++) begin
      step(t, n);
      total++;
      if (wt !== gold[t] || wValid !== 1'b1) begin
        bad++;
        $display("FAIL b2b_first t=%0d wt=%h exp=%h v=%b", t, wt, gold[t], wValid);
      end
    end
    compute_gold(headerTail, 32'h1);
    for (int t = 0; t < 64; t++) begin
      step(t, 32'h1);
      total++;
      if (wt !== gold[t] || wValid !== 1'b1 || nonceOut !== 32'h1 || seqErr !== 1'b0 || blockDone !== (t == 63)) begin
        bad++;
        $display("FAIL b2b_second t=%0d wt=%h exp=%h v=%b nonce=%h err=%b", t, wt, gold[t], wValid, nonceOut, seqErr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_nonce_capture();
    test_stall();
    test_out_of_seq();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
